seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Downstream display stage of the clock: takes the live hour/minute counts and drives a 4-digit, common-scan 7-segment display. Each scan frame starts with a snapshot of the inputs. A sequential double-dabble then converts the snapshot to BCD, so digits never tear mid-frame. The block multiplexes one digit at a time with per-field blanking and a colon on digit 2.

## Interface
- SCAN_DIV_W, 10: prescaler width; the scan advances one digit every 2^SCAN_DIV_W cycles; legal range 4..16.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- hour  in  6  hour count, 0..23 nominal; bit 5 unused by the clock, tie 0
- minute  in  6  minute count, 0..59 nominal
- show_hour  in  1  1 = drive hour digits (3,2); 0 = blank them
- show_minute  in  1  1 = drive minute digits (1,0); 0 = blank them
- colon  in  1  1 = light dp on digit 2
- segment  out  7  {g,f,e,d,c,b,a}, active-high
- dp  out  1  decimal point, active-high
- digit_en  out  4  one-hot digit select, active-high; bit0 = minute units, bit3 = hour tens
- busy  out  1  conversion in progress (state != S_IDLE)

## Operation
- Prescaler: free-running SCAN_DIV_W-bit counter. `tick` is asserted when the counter is all-ones.
- Digit index: 2-bit index, advances on each `tick`, wraps 3->0. Frame start = `tick` while index==3.
- FSM states: S_CAPTURE, S_CONV, S_LOAD, S_IDLE. Reset state is S_CAPTURE.
- S_CAPTURE, 1 cycle:
  - latch hour, minute, show_hour, show_minute and colon into snapshot registers;
  - load both dabble shift registers;
  - go to S_CONV.
- S_CONV, exactly 6 cycles: shift-and-add-3 on both fields in parallel; then go to S_LOAD.
- S_LOAD, 1 cycle: write the 4 BCD digits and the snapshot show/colon flags into the display registers; go to S_IDLE.
- S_IDLE: frame start moves the FSM to S_CAPTURE on the next cycle.
  - A frame start seen in any other state is ignored; it cannot occur when SCAN_DIV_W >= 4.
- No range clamping. Values are converted as given: hour 31 shows "31", minute 63 shows "63".
- The hour tens digit is never zero-suppressed.
- Decode table: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F (hex). Codes above 9 decode to 00.
- Blanking: a digit whose field show flag is 0 outputs segment=00. digit_en keeps scanning.
- dp = 1 only when index==2 and the display colon flag is 1.
- segment, dp and digit_en are registered: they show the current index and display registers, one cycle late.

## Timing
- Values during reset:
  - segment, dp: 0; digit_en: 0000; index: 0; prescaler: 0;
  - display digits: 0; display show flags: 0; busy: 1 (S_CAPTURE).
- After reset release:
  - edge 1: S_CAPTURE captures the inputs and digit_en becomes 0001 (blank, show flags still 0);
  - edge 8: display registers are loaded and busy drops;
  - edge 9: outputs show the loaded values.
- Input-to-display latency: from the next frame start, 1 (to S_CAPTURE) + 1 + 6 + 1 + 1 = 10 cycles.
- Each digit is held for 2^SCAN_DIV_W cycles; one frame is 4 * 2^SCAN_DIV_W cycles.
- Input changes between captures have no effect until the next frame start.
- Reset asserted mid-operation, including mid-S_CONV: all state aborts immediately to the reset values. There is no partial load.

## Structure
- Shared package seven_seg_pkg:
  - FSM state enum;
  - the ten segment code constants;
  - DIGIT_COUNT = 4;
  - CONV_CYCLES = 6.
- Sub-module bcd_dabble6: holds one 6-bit to 2-digit shift-add-3 datapath with `load` and `shift` strobes.
  - Instantiated twice, for hour and minute.
  - The FSM stays in seven_seg_scanner.

## Test plan
All scenarios run with SCAN_DIV_W=4.
- Reset release with hour=12, minute=34, show both = 1 -> busy falls 8 edges after release. digit_en/segment then cycle 0001/66, 0010/4F, 0100/5B, 1000/06, each held 16 cycles.
- hour=23, minute=59 -> segments 6F, 6D, 4F, 5B. Change to 0/0 mid-frame -> no change until the next frame start; segments are 3F on all digits 10 cycles later.
- show_hour=0, hour=12, minute=34 -> segment=00 while digit_en is 0100 or 1000; minute digits unaffected.
- colon=1 -> dp=1 exactly while digit_en=0100, dp=0 on the other digits.
- hour=31, minute=63 -> digits show 3,6 | 3,1 (segments 4F, 7D, 06, 4F from digit 0 up).
- reset pulsed 3 cycles into S_CONV -> outputs go to 0 immediately. After release the full 8-edge conversion reruns and shows the current inputs.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_CONV,
        S_LOAD,
        S_IDLE
    } state_t;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam int DIGIT_COUNT = 4;
    localparam int CONV_CYCLES = 6;

    // BCD digit to segment pattern; non-decimal codes go dark
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scanner_dabble.sv
// 6-bit binary to two BCD digits, one shift-and-add-3 step per `shift`.
// Six shifts after `load` leave the result in tens/units. Inputs up to 63
// are handled, so out-of-range hours/minutes convert faithfully.
module bcd_dabble6 (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // {tens, units, binary} working register
    logic [13:0] sr;
    logic [13:0] adj;

    // Add 3 to any BCD nibble >= 5 ahead of the shift
    always_comb begin
        adj = sr;
        if (sr[13:10] >= 4'd5) adj[13:10] = sr[13:10] + 4'd3;
        if (sr[9:6]   >= 4'd5) adj[9:6]   = sr[9:6]   + 4'd3;
    end

    // Load the binary value, then shift the adjusted word left
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     sr <= '0;
        else if (load)  sr <= {8'd0, bin};
        else if (shift) sr <= {adj[12:0], 1'b0};
    end

    assign tens  = sr[13:10];
    assign units = sr[9:6];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment driver for hour:minute. Each frame
// snapshots the inputs, converts them to BCD over several cycles and then
// swaps the result into the display registers in one step, so a frame never
// shows a half-updated time.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV_W = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             hour,
    input  logic [5:0]             minute,
    input  logic                   show_hour,
    input  logic                   show_minute,
    input  logic                   colon,
    output logic [6:0]             segment,
    output logic                   dp,
    output logic [DIGIT_COUNT-1:0] digit_en,
    output logic                   busy
);

    logic [SCAN_DIV_W-1:0] prescale;
    logic [1:0]            index;
    logic                  tick;
    logic                  frame_start;

    state_t     state;
    logic [2:0] conv_cnt;

    // Snapshot of the flags; the dabble registers hold the value snapshot
    logic snap_show_h, snap_show_m, snap_colon;

    // Display registers, digit 0 = minute units .. digit 3 = hour tens
    logic [DIGIT_COUNT-1:0][3:0] disp_digit;
    logic disp_show_h, disp_show_m, disp_colon;

    logic [3:0] hr_tens, hr_units, min_tens, min_units;

    assign tick        = &prescale;
    assign frame_start = tick && (index == 2'd3);
    assign busy        = (state != S_IDLE);

    // Free-running prescaler and scan index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            index    <= '0;
        end else begin
            prescale <= prescale + 1'b1;
            if (tick) index <= index + 2'd1;
        end
    end

    bcd_dabble6 u_hour_bcd (
        .clock (clock),
        .reset (reset),
        .load  (state == S_CAPTURE),
        .shift (state == S_CONV),
        .bin   (hour),
        .tens  (hr_tens),
        .units (hr_units)
    );

    bcd_dabble6 u_minute_bcd (
        .clock (clock),
        .reset (reset),
        .load  (state == S_CAPTURE),
        .shift (state == S_CONV),
        .bin   (minute),
        .tens  (min_tens),
        .units (min_units)
    );

    // Capture -> convert -> load sequencer, restarted by each frame start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_CAPTURE;
            conv_cnt    <= '0;
            snap_show_h <= 1'b0;
            snap_show_m <= 1'b0;
            snap_colon  <= 1'b0;
            disp_digit  <= '0;
            disp_show_h <= 1'b0;
            disp_show_m <= 1'b0;
            disp_colon  <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    snap_show_h <= show_hour;
                    snap_show_m <= show_minute;
                    snap_colon  <= colon;
                    conv_cnt    <= '0;
                    state       <= S_CONV;
                end
                S_CONV: begin
                    conv_cnt <= conv_cnt + 3'd1;
                    if (conv_cnt == 3'(CONV_CYCLES - 1)) state <= S_LOAD;
                end
                S_LOAD: begin
                    disp_digit  <= {hr_tens, hr_units, min_tens, min_units};
                    disp_show_h <= snap_show_h;
                    disp_show_m <= snap_show_m;
                    disp_colon  <= snap_colon;
                    state       <= S_IDLE;
                end
                default: begin
                    if (frame_start) state <= S_CAPTURE;
                end
            endcase
        end
    end

    // Registered digit drive for the current scan position
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            segment  <= '0;
            dp       <= 1'b0;
            digit_en <= '0;
        end else begin
            digit_en <= DIGIT_COUNT'(1) << index;
            segment  <= (index[1] ? disp_show_h : disp_show_m)
                        ? seg_decode(disp_digit[index]) : 7'h00;
            dp       <= (index == 2'd2) && disp_colon;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner at SCAN_DIV_W=4 (16-cycle digits).
module tb_seven_seg_scanner;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] hour, minute;
    logic       show_hour, show_minute, colon;
    logic [6:0] segment;
    logic       dp;
    logic [3:0] digit_en;
    logic       busy;

    seven_seg_scanner #(.SCAN_DIV_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .hour        (hour),
        .minute      (minute),
        .show_hour   (show_hour),
        .show_minute (show_minute),
        .colon       (colon),
        .segment     (segment),
        .dp          (dp),
        .digit_en    (digit_en),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: each new digit presentation pops one expectation; also checks hold length
    logic [3:0] prev_en  = 4'd0;
    int         hold_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_en  <= 4'd0;
            hold_cnt <= 0;
        end else if (digit_en != prev_en) begin
            exp_t e;
            if (prev_en != 4'd0) check("hold_len", hold_cnt, 16);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_digit_en", digit_en, e.en);
                check("sb_segment", segment, e.seg);
                check("sb_dp", dp, e.dp);
            end
            prev_en  <= digit_en;
            hold_cnt <= 1;
        end else begin
            hold_cnt <= hold_cnt + 1;
        end
    end

    // Expected codes for the rest of this frame plus the next frame's first digit
    task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic col);
        sb.push_back('{en: 4'b0010, seg: s1, dp: 1'b0});
        sb.push_back('{en: 4'b0100, seg: s2, dp: col});
        sb.push_back('{en: 4'b1000, seg: s3, dp: 1'b0});
        sb.push_back('{en: 4'b0001, seg: s0, dp: 1'b0});
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n = 0;
        while (busy !== lvl && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(nm, busy, lvl);
    endtask

    task automatic set_in(input int h, input int m, input logic sh, input logic sm, input logic col);
        hour        = 6'(h);
        minute      = 6'(m);
        show_hour   = sh;
        show_minute = sm;
        colon       = col;
    endtask

    task automatic run_frame(input int h, input int m, input logic sh, input logic sm,
                             input logic col, input logic [6:0] s0, s1, s2, s3);
        set_in(h, m, sh, sm, col);
        wait_busy(1'b1, "frame_start");
        wait_busy(1'b0, "conv_done");
        push_frame(s0, s1, s2, s3, col);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(nm, sb.size(), 0);
    endtask

    // Release reset at a negedge; conversion must finish on edge 8, show on edge 9
    task automatic release_and_count(input logic [6:0] s0, input string nm);
        int n;
        reset = 1'b1;
        @(negedge clock);
        check({nm, "_edge1_en"}, digit_en, 4'b0001);
        check({nm, "_edge1_seg"}, segment, 7'h00);
        n = 1;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_busy_edge"}, n, 8);
        @(negedge clock);
        check({nm, "_edge9_en"}, digit_en, 4'b0001);
        check({nm, "_edge9_seg"}, segment, s0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        set_in(12, 34, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_segment", segment, 7'h00);
        check("rst_dp", dp, 1'b0);
        check("rst_digit_en", digit_en, 4'b0000);
        check("rst_busy", busy, 1'b1);

        // 12:34 from reset
        release_and_count(7'h66, "boot");
        push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0);

        // 23:59, then inputs change mid-frame to 00:00
        run_frame(23, 59, 1'b1, 1'b1, 1'b0, 7'h6F, 7'h6D, 7'h4F, 7'h5B);
        begin
            int n = 0;
            while (digit_en !== 4'b0100 && n < 100) begin
                @(negedge clock);
                n++;
            end
            check("reach_digit2", digit_en, 4'b0100);
        end
        set_in(0, 0, 1'b1, 1'b1, 1'b0);
        wait_busy(1'b1, "frame_start_zero");
        repeat (8) @(negedge clock);
        check("latency9_old", segment, 7'h6F);
        @(negedge clock);
        check("latency10_new", segment, 7'h3F);
        check("latency10_en", digit_en, 4'b0001);
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0);

        // Hour blanked
        run_frame(12, 34, 1'b0, 1'b1, 1'b0, 7'h66, 7'h4F, 7'h00, 7'h00);
        // Colon lit
        run_frame(12, 34, 1'b1, 1'b1, 1'b1, 7'h66, 7'h4F, 7'h5B, 7'h06);
        // No clamping: 31:63
        run_frame(31, 63, 1'b1, 1'b1, 1'b0, 7'h4F, 7'h7D, 7'h06, 7'h4F);
        drain("drain_main");

        // Reset three cycles into conversion
        set_in(7, 45, 1'b1, 1'b1, 1'b1);
        wait_busy(1'b0, "idle_before_abort");
        wait_busy(1'b1, "frame_start_abort");
        repeat (4) @(negedge clock);
        check("pre_abort_seg", segment, 7'h4F);
        reset = 1'b0;
        #1;
        check("abort_segment", segment, 7'h00);
        check("abort_dp", dp, 1'b0);
        check("abort_digit_en", digit_en, 4'b0000);
        check("abort_busy", busy, 1'b1);
        repeat (2) @(negedge clock);
        release_and_count(7'h6D, "rerun");
        push_frame(7'h6D, 7'h66, 7'h07, 7'h3F, 1'b1);
        drain("drain_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
